// File: rtl/branch_pc_unit.sv
// branch_pc_unit: owns the PC, resolves RV32I branches plus JAL/JALR, holds on stall, pulses flush after redirects.
// Optional saturating branch statistics are enabled by defining BRANCH_STATS_EN.
module branch_pc_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     PC_STEP  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic              jump,
  input  logic              jalr,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   pc,
  output logic              pc_valid,
  output logic [XLEN-1:0]   link_addr,
  output logic              branch_taken,
  output logic              illegal_br,
  output logic              flush,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] taken_count
);

  typedef enum logic [2:0] {
    F3_EQ  = 3'b000,
    F3_NE  = 3'b001,
    F3_LT  = 3'b100,
    F3_GE  = 3'b101,
    F3_LTU = 3'b110,
    F3_GEU = 3'b111
  } funct3_e;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  // JALR targets drop bit 0 only when the PC is byte-addressed.
  localparam logic [XLEN-1:0] JALR_MASK = (PC_STEP > 1) ? {{(XLEN-1){1'b1}}, 1'b0} : '1;

  logic            cond;
  logic            cond_taken;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] jalr_target;

  always_comb begin
    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    cond       = 1'b0;
    illegal_br = 1'b0;
    case (funct3_e'(funct3))
      F3_EQ:   cond = (rs1_data == rs2_data);
      F3_NE:   cond = (rs1_data != rs2_data);
      F3_LT:   cond = ($signed(rs1_data) <  $signed(rs2_data));
      F3_GE:   cond = ($signed(rs1_data) >= $signed(rs2_data));
      F3_LTU:  cond = (rs1_data <  rs2_data);
      F3_GEU:  cond = (rs1_data >= rs2_data);
      default: illegal_br = branch;
    endcase
  end

  assign cond_taken   = branch & cond;
  assign branch_taken = jalr | jump | cond_taken;
  assign link_addr    = pc + STEP;
  assign jalr_target  = (rs1_data + imm) & JALR_MASK;

  always_comb begin
    next_pc = pc + STEP;
    if (jalr)                    next_pc = jalr_target;
    else if (jump || cond_taken) next_pc = pc + imm;
  end

  // A stalled cycle drops the redirect; it is re-resolved when the stall releases.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
      flush    <= 1'b0;
    end else begin
      pc_valid <= 1'b1;
      if (stall) begin
        flush <= 1'b0;
      end else begin
        pc    <= next_pc;
        flush <= branch_taken;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else if (!stall && branch) begin
      if (branch_count != '1)              branch_count <= branch_count + STAT_W'(1);
      if (cond_taken && taken_count != '1) taken_count  <= taken_count + STAT_W'(1);
    end
  end
`else
  assign branch_count = '0;
  assign taken_count  = '0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: two instances (word- and byte-addressed PC) against a spec-level model.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch, jump, jalr;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, imm;

  logic [31:0] pc_a, link_a, pc_b, link_b;
  logic        valid_a, taken_a, illegal_a, flush_a;
  logic        valid_b, taken_b, illegal_b, flush_b;
  logic [15:0] bc_a, tc_a;
  logic [1:0]  bc_b, tc_b;

  int checks = 0;
  int errors = 0;

`ifdef BRANCH_STATS_EN
  localparam int EXP_SAT = 3;
`else
  localparam int EXP_SAT = 0;
`endif

  // Per-instance configuration and model state (index 0: PC_STEP=1, index 1: PC_STEP=4)
  int unsigned step [2] = '{1, 4};
  logic [31:0] rst_pc [2] = '{32'h0, 32'h100};
  int unsigned cmax [2] = '{65535, 3};
  logic [31:0] m_pc [2];
  logic        m_valid [2], m_flush [2];
  int unsigned m_bc [2], m_tc [2];

  always #5 clk = ~clk;

  branch_pc_unit #(.XLEN(32), .PC_STEP(1), .RESET_PC(32'h0), .STAT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .jump(jump), .jalr(jalr),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .pc(pc_a), .pc_valid(valid_a), .link_addr(link_a), .branch_taken(taken_a),
    .illegal_br(illegal_a), .flush(flush_a), .branch_count(bc_a), .taken_count(tc_a));

  branch_pc_unit #(.XLEN(32), .PC_STEP(4), .RESET_PC(32'h100), .STAT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .jump(jump), .jalr(jalr),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .pc(pc_b), .pc_valid(valid_b), .link_addr(link_b), .branch_taken(taken_b),
    .illegal_br(illegal_b), .flush(flush_b), .branch_count(bc_b), .taken_count(tc_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa = int'(a);
    int sb = int'(b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input int i);
    logic [31:0] t;
    bit ct = branch && ref_cond(funct3, rs1_data, rs2_data);
    if (jalr) begin
      t = rs1_data + imm;
      if (step[i] > 1) t[0] = 1'b0;
    end else if (jump || ct) begin
      t = m_pc[i] + imm;
    end else begin
      t = m_pc[i] + step[i];
    end
    return t;
  endfunction

  task automatic check_inst(input int i);
    bit ct  = branch && ref_cond(funct3, rs1_data, rs2_data);
    bit tk  = jalr || jump || ct;
    bit ill = branch && (funct3 == 3'd2 || funct3 == 3'd3);
    logic [31:0] lk = m_pc[i] + step[i];
    if (i == 0) begin
      check("a_pc", pc_a, m_pc[0]);          check("a_valid", 32'(valid_a), 32'(m_valid[0]));
      check("a_flush", 32'(flush_a), 32'(m_flush[0]));
      check("a_link", link_a, lk);           check("a_taken", 32'(taken_a), 32'(tk));
      check("a_illegal", 32'(illegal_a), 32'(ill));
      check("a_bcount", 32'(bc_a), m_bc[0]); check("a_tcount", 32'(tc_a), m_tc[0]);
    end else begin
      check("b_pc", pc_b, m_pc[1]);          check("b_valid", 32'(valid_b), 32'(m_valid[1]));
      check("b_flush", 32'(flush_b), 32'(m_flush[1]));
      check("b_link", link_b, lk);           check("b_taken", 32'(taken_b), 32'(tk));
      check("b_illegal", 32'(illegal_b), 32'(ill));
      check("b_bcount", 32'(bc_b), m_bc[1]); check("b_tcount", 32'(tc_b), m_tc[1]);
    end
  endtask

  task automatic model_edge(input int i);
    bit ct = branch && ref_cond(funct3, rs1_data, rs2_data);
    if (reset) begin
      m_pc[i] = rst_pc[i]; m_valid[i] = 1'b0; m_flush[i] = 1'b0; m_bc[i] = 0; m_tc[i] = 0;
    end else begin
      m_valid[i] = 1'b1;
      if (stall) begin
        m_flush[i] = 1'b0;
      end else begin
        m_flush[i] = jalr || jump || ct;
        m_pc[i]    = ref_target(i);
`ifdef BRANCH_STATS_EN
        if (branch && m_bc[i] < cmax[i]) m_bc[i]++;
        if (ct && m_tc[i] < cmax[i])     m_tc[i]++;
`endif
      end
    end
  endtask

  // Inputs are already applied at the negedge; check, then let the model follow the rising edge.
  task automatic run_cycle(input bit do_check);
    #2;
    if (do_check) begin
      check_inst(0);
      check_inst(1);
    end
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit s, input bit br, input bit j, input bit jr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im);
    reset = r; stall = s; branch = br; jump = j; jalr = jr;
    funct3 = f3; rs1_data = a; rs2_data = b; imm = im;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
      run_cycle(1);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    @(negedge clk);
    run_cycle(0);
    check("rst_pc_a", pc_a, 32'h0);
    check("rst_pc_b", pc_b, 32'h100);
    check("rst_valid", 32'(valid_a), 32'h0);

    // Sequential counting out of reset
    idle(3);
    check("seq_pc", pc_a, 32'd3);
    check("seq_valid", 32'(valid_a), 32'h1);
    idle(7);
    check("seq_pc10", pc_a, 32'd10);

    // BEQ taken with negative offset, then the flush pulse drops
    drive(0, 0, 1, 0, 0, 3'b000, 32'd5, 32'd5, -32'sd4);
    run_cycle(1);
    check("beq_pc", pc_a, 32'd6);
    check("beq_flush", 32'(flush_a), 32'h1);
    idle(1);
    check("beq_flush_off", 32'(flush_a), 32'h0);
    drive(0, 0, 1, 0, 0, 3'b001, 32'd5, 32'd5, -32'sd4);
    run_cycle(1);
    check("bne_pc", pc_a, 32'd8);

    // Signed vs unsigned compares and an illegal funct3
    drive(0, 0, 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'd2);
    run_cycle(1);
    check("blt_pc", pc_a, 32'd10);
    drive(0, 0, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'd2);
    run_cycle(1);
    check("bltu_pc", pc_a, 32'd11);
    drive(0, 0, 1, 0, 0, 3'b010, 32'd0, 32'd0, 32'd2);
    #1 check("illegal", 32'(illegal_a), 32'h1);
    run_cycle(1);
    check("illegal_pc", pc_a, 32'd12);

    // All redirects at once: JALR wins, bit 0 cleared only for PC_STEP=4
    drive(0, 0, 1, 1, 1, 3'b000, 32'd100, 32'd100, 32'd3);
    run_cycle(1);
    check("jalr_pc_b", pc_b, 32'd102);
    check("jalr_pc_a", pc_a, 32'd103);

    // Stalled taken branch: hold and no flush, redirect on release
    drive(0, 1, 1, 0, 0, 3'b000, 32'd7, 32'd7, 32'd20);
    run_cycle(1);
    run_cycle(1);
    check("stall_pc", pc_a, 32'd103);
    check("stall_flush", 32'(flush_a), 32'h0);
    stall = 1'b0;
    run_cycle(1);
    check("release_pc", pc_a, 32'd123);
    check("release_flush", 32'(flush_a), 32'h1);

    // Reset discards a simultaneous jump
    drive(1, 0, 0, 1, 0, 3'b000, 0, 0, 32'd50);
    run_cycle(1);
    check("rst_jump_pc", pc_a, 32'h0);
    check("rst_jump_flush", 32'(flush_a), 32'h0);

    // Five back-to-back taken branches saturate the 2-bit counters
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 0, 0, 3'b000, 32'd1, 32'd1, 32'd1);
      run_cycle(1);
      check("b2b_flush", 32'(flush_a), 32'h1);
    end
    check("sat_bcount", 32'(bc_b), 32'(EXP_SAT));
    check("sat_tcount", 32'(tc_b), 32'(EXP_SAT));

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, b, im;
      a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      im = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
            a, b, im);
      run_cycle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
